// File: rtl/divider_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the shared divider.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface divider_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             gnt0;
  logic             gnt1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic             err_out;
  logic             tmo_out;
  logic [WIDTH-1:0] div_x;
  logic [WIDTH-1:0] div_y;
  logic             div_go;
  logic             div_done;
  logic             div_err;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  modport master (
    input  req0, req1, x0, y0, x1, y1,
    input  div_done, div_err, div_q, div_r,
    output gnt0, gnt1, ack0, ack1, q_out, r_out, err_out, tmo_out,
    output div_x, div_y, div_go
  );

  modport slave (
    output req0, req1, x0, y0, x1, y1,
    output div_done, div_err, div_q, div_r,
    input  gnt0, gnt1, ack0, ack1, q_out, r_out, err_out, tmo_out,
    input  div_x, div_y, div_go
  );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one integer divider between two requesters,
// with a watchdog that aborts an operation whose done never arrives.
//
// state   | meaning
// IDLE    | waiting for a request; grants and latches operands
// ISSUE   | div_go high, waiting for div_done or watchdog expiry
// RESP    | one-cycle ack to the winner, result valid
// RECOVER | wait for div_done to drop before the next grant
module divider_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic          CLK,
  input  logic          rst,
  divider_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state_q;
  logic             last_q;
  logic             winner_q;
  logic             winner_d;
  logic [7:0]       cnt_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             ack0_q;
  logic             ack1_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             err_q;
  logic             tmo_q;
  logic [WIDTH-1:0] div_x_q;
  logic [WIDTH-1:0] div_y_q;
  logic             div_go_q;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    winner_d = 1'b0;
    if (bus.req0 && bus.req1) begin
      winner_d = ~last_q;
    end else if (bus.req1) begin
      winner_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      winner_q <= 1'b0;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      q_q      <= '0;
      r_q      <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      div_x_q  <= '0;
      div_y_q  <= '0;
      div_go_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            winner_q <= winner_d;
            div_x_q  <= winner_d ? bus.x1 : bus.x0;
            div_y_q  <= winner_d ? bus.y1 : bus.y0;
            gnt0_q   <= ~winner_d;
            gnt1_q   <= winner_d;
            div_go_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.div_done) begin
            q_q      <= bus.div_q;
            r_q      <= bus.div_r;
            err_q    <= bus.div_err;
            tmo_q    <= 1'b0;
            div_go_q <= 1'b0;
            ack0_q   <= ~winner_q;
            ack1_q   <= winner_q;
            state_q  <= RESP;
          end else if (cnt_q == TMO_LAST) begin
            q_q      <= '0;
            r_q      <= '0;
            err_q    <= 1'b1;
            tmo_q    <= 1'b1;
            div_go_q <= 1'b0;
            ack0_q   <= ~winner_q;
            ack1_q   <= winner_q;
            state_q  <= RESP;
          end
        end
        RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          last_q  <= winner_q;
          state_q <= RECOVER;
        end
        RECOVER: begin
          if (!bus.div_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.q_out   = q_q;
  assign bus.r_out   = r_q;
  assign bus.err_out = err_q;
  assign bus.tmo_out = tmo_q;
  assign bus.div_x   = div_x_q;
  assign bus.div_y   = div_y_q;
  assign bus.div_go  = div_go_q;

endmodule
